// File: rtl/bcd_to_xs3_seq.sv
// Multi-digit BCD to excess-3 encoder: captures a word, converts one digit per clock (LSD first), then holds the result.
// Latency DIGITS cycles from accept to out_valid; out_valid is held with data stable until out_ready, in_ready low outside IDLE.
module bcd_to_xs3_seq #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_bcd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_xs3,
   output logic [DIGITS-1:0]     out_err
);

   localparam int W  = 4 * DIGITS;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [W-1:0]      cap_q, cap_d;
   logic [W-1:0]      xs3_q, xs3_d;
   logic [DIGITS-1:0] err_q, err_d;
   logic              vld_q, vld_d;
   logic              rdy_q, rdy_d;
   logic [3:0]        dig;
   logic [3:0]        dig_xs3;
   logic              dig_err;

   always_comb begin
      dig     = cap_q[4*cnt_q +: 4];
      dig_err = (dig > 4'd9);
      dig_xs3 = dig_err ? 4'b0000 : dig + 4'd3;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      xs3_d   = xs3_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (in_valid && rdy_q) begin
               cap_d   = in_bcd;
               xs3_d   = '0;
               err_d   = '0;
               cnt_d   = '0;
               state_d = CONV;
            end
         end
         CONV: begin
            xs3_d[4*cnt_q +: 4] = dig_xs3;
            err_d[cnt_q]        = dig_err;
            if (cnt_q == LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Registered handshake flags so both read 0 while in reset.
      vld_d = (state_d == DONE);
      rdy_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cap_q   <= '0;
         xs3_q   <= '0;
         err_q   <= '0;
         vld_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
         xs3_q   <= xs3_d;
         err_q   <= err_d;
         vld_q   <= vld_d;
         rdy_q   <= rdy_d;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = vld_q;
   assign out_xs3   = xs3_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_bcd_to_xs3_seq.sv
// Directed bench for bcd_to_xs3_seq with DIGITS=4; inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_bcd_to_xs3_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_bcd;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_xs3;
   logic [3:0]  out_err;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bcd_to_xs3_seq #(.DIGITS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bcd    (in_bcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_xs3   (out_xs3),
      .out_err   (out_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [15:0] w);
      in_bcd   = w;
      in_valid = 1'b1;
      chk("accept_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      in_bcd   = 16'($urandom);
      chk("busy_in_ready", 32'(in_ready), 32'd0);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         lat++;
         if (out_valid) break;
      end
   endtask

   task automatic run(input string tag, input logic [15:0] w,
                      input logic [15:0] exp_x, input logic [3:0] exp_e);
      int lat;
      accept(w);
      wait_valid(lat);
      chk({tag, "_latency"}, 32'(lat), 32'd4);
      chk({tag, "_xs3"}, 32'(out_xs3), 32'(exp_x));
      chk({tag, "_err"}, 32'(out_err), 32'(exp_e));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_handoff_vld"}, 32'(out_valid), 32'd0);
      chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      logic [15:0] held;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bcd    = 16'h0;
      out_ready = 1'b0;

      // Reset
      repeat (3) tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_xs3", 32'(out_xs3), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // Main function and boundaries
      run("w1234", 16'h1234, 16'h4567, 4'b0000);
      run("w9009", 16'h9009, 16'hC33C, 4'b0000);
      run("w0000", 16'h0000, 16'h3333, 4'b0000);
      run("w0A5F", 16'h0A5F, 16'h3080, 4'b0101);
      run("wFFFF", 16'hFFFF, 16'h0000, 4'b1111);

      // Backpressure in DONE with a competing input word
      accept(16'h2468);
      wait_valid(lat);
      chk("bp_latency", 32'(lat), 32'd4);
      held     = out_xs3;
      chk("bp_xs3", 32'(held), 32'h579B);
      in_bcd   = 16'h9999;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_vld", 32'(out_valid), 32'd1);
         chk("bp_hold_xs3", 32'(out_xs3), 32'(held));
         chk("bp_hold_rdy", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_handoff_vld", 32'(out_valid), 32'd0);
      chk("bp_idle_rdy", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_next_accepted", 32'(in_ready), 32'd0);
      wait_valid(lat);
      chk("bp_next_latency", 32'(lat), 32'd4);
      chk("bp_next_xs3", 32'(out_xs3), 32'hCCCC);
      // out_ready held high: DONE lasts a single cycle
      tick();
      chk("bp_1cyc_done", 32'(out_valid), 32'd0);
      chk("bp_1cyc_rdy", 32'(in_ready), 32'd1);
      out_ready = 1'b0;

      // Abort mid-conversion
      accept(16'h1234);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      tick();
      chk("abort_vld", 32'(out_valid), 32'd0);
      chk("abort_xs3", 32'(out_xs3), 32'd0);
      chk("abort_err", 32'(out_err), 32'd0);
      chk("abort_rdy", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort_no_result", 32'(out_valid), 32'd0);
      end
      chk("abort_xs3_after", 32'(out_xs3), 32'd0);
      run("w5678", 16'h5678, 16'h89AB, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
